// File: rtl/board_generator.sv
// Minesweeper board generator for a 5x5 board held in an external RAM.
//
// On a start request the board RAM (cells 0..24) is cleared, NUM_MINES mines
// (value 10) are placed at LFSR-chosen cells avoiding a caller-supplied safe
// cell, then every non-mine cell is overwritten with its neighbour mine count.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   reset        - asynchronous active-high reset
//   start        - one-cycle request to build a new board (ignored while busy)
//   seed         - LFSR seed, sampled with start (0 is replaced by 8'h01)
//   safe_cell    - cell index (row*5+col) kept mine-free; >=25 disables it
//   mem_wEn      - RAM write enable (RAM commits on the falling edge)
//   mem_addr     - RAM shared read/write address
//   mem_dataIn   - RAM write data
//   mem_dataOut  - RAM combinational read data at mem_addr
//   busy         - high from start acceptance until the done cycle
//   done         - one-cycle pulse when the board is complete
module board_generator #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned NUM_MINES     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               seed,
  input  logic [4:0]               safe_cell,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut,
  output logic                     busy,
  output logic                     done
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StClear     = 3'd1;
  localparam logic [2:0] StProbe     = 3'd2;
  localparam logic [2:0] StWriteMine = 3'd3;
  localparam logic [2:0] StCheck     = 3'd4;
  localparam logic [2:0] StNeigh     = 3'd5;
  localparam logic [2:0] StWriteCnt  = 3'd6;
  localparam logic [2:0] StDone      = 3'd7;

  localparam logic [DATA_WIDTH-1:0] MineVal   = DATA_WIDTH'(10);
  localparam logic [4:0]            LastCell  = 5'd24;
  localparam logic [4:0]            MineLimit = 5'(NUM_MINES);

  logic [2:0] state_q, state_d;
  logic [4:0] cell_q, cell_d;    // clear index, then cell under count
  logic [2:0] nb_q, nb_d;        // neighbour offset index 0..7
  logic [3:0] acc_q, acc_d;      // neighbour mine accumulator
  logic [4:0] mines_q, mines_d;  // mines placed so far
  logic [7:0] lfsr_q, lfsr_d;
  logic [4:0] cand_q, cand_d;    // accepted candidate, held for WRITE_MINE
  logic [4:0] safe_q, safe_d;

  logic [7:0] lfsr_next;
  logic [4:0] cand;
  logic       is_mine;
  logic [2:0] row, col;
  logic       nb_top, nb_bot, nb_left, nb_right;
  logic [4:0] nb_off;
  logic       on_board;
  logic [4:0] nb_addr;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand      = lfsr_q[4:0];
  assign is_mine   = (mem_dataOut == MineVal);

  assign row = 3'(cell_q / 5'd5);
  assign col = 3'(cell_q % 5'd5);

  // Offset order: (-1,-1) (-1,0) (-1,+1) (0,-1) (0,+1) (+1,-1) (+1,0) (+1,+1).
  // Address offsets are mod-32 so cell_q + nb_off lands on the neighbour.
  always_comb begin
    nb_top   = 1'b0;
    nb_bot   = 1'b0;
    nb_left  = 1'b0;
    nb_right = 1'b0;
    nb_off   = 5'd0;
    unique case (nb_q)
      3'd0: begin nb_top = 1'b1; nb_left  = 1'b1; nb_off = 5'd26; end
      3'd1: begin nb_top = 1'b1;                  nb_off = 5'd27; end
      3'd2: begin nb_top = 1'b1; nb_right = 1'b1; nb_off = 5'd28; end
      3'd3: begin                nb_left  = 1'b1; nb_off = 5'd31; end
      3'd4: begin                nb_right = 1'b1; nb_off = 5'd1;  end
      3'd5: begin nb_bot = 1'b1; nb_left  = 1'b1; nb_off = 5'd4;  end
      3'd6: begin nb_bot = 1'b1;                  nb_off = 5'd5;  end
      3'd7: begin nb_bot = 1'b1; nb_right = 1'b1; nb_off = 5'd6;  end
      default: ;
    endcase
  end

  assign on_board = !(nb_top && row == 3'd0) && !(nb_bot && row == 3'd4) &&
                    !(nb_left && col == 3'd0) && !(nb_right && col == 3'd4);
  // Off-board neighbours still take their cycle, parked on the cell itself.
  assign nb_addr  = on_board ? cell_q + nb_off : cell_q;

  // Moore outputs decoded from registered state.
  always_comb begin
    mem_wEn    = 1'b0;
    mem_addr   = '0;
    mem_dataIn = '0;
    unique case (state_q)
      StClear: begin
        mem_wEn  = 1'b1;
        mem_addr = ADDRESS_WIDTH'(cell_q);
      end
      StProbe: mem_addr = ADDRESS_WIDTH'(cand);
      StWriteMine: begin
        mem_wEn    = 1'b1;
        mem_addr   = ADDRESS_WIDTH'(cand_q);
        mem_dataIn = MineVal;
      end
      StCheck: mem_addr = ADDRESS_WIDTH'(cell_q);
      StNeigh: mem_addr = ADDRESS_WIDTH'(nb_addr);
      StWriteCnt: begin
        mem_wEn    = 1'b1;
        mem_addr   = ADDRESS_WIDTH'(cell_q);
        mem_dataIn = DATA_WIDTH'(acc_q);
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle) && (state_q != StDone);
  assign done = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    nb_d    = nb_q;
    acc_d   = acc_q;
    mines_d = mines_q;
    lfsr_d  = lfsr_q;
    cand_d  = cand_q;
    safe_d  = safe_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          safe_d  = safe_cell;
          lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
          cell_d  = 5'd0;
          mines_d = 5'd0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (cell_q == LastCell) begin
          cell_d  = 5'd0;
          state_d = StProbe;
        end else begin
          cell_d = cell_q + 5'd1;
        end
      end
      StProbe: begin
        lfsr_d = lfsr_next;
        if (cand < 5'd25 && cand != safe_q && !is_mine) begin
          cand_d  = cand;
          state_d = StWriteMine;
        end
      end
      StWriteMine: begin
        mines_d = mines_q + 5'd1;
        if (mines_q + 5'd1 == MineLimit) begin
          cell_d  = 5'd0;
          state_d = StCheck;
        end else begin
          state_d = StProbe;
        end
      end
      StCheck: begin
        if (is_mine) begin
          if (cell_q == LastCell) begin
            state_d = StDone;
          end else begin
            cell_d = cell_q + 5'd1;
          end
        end else begin
          acc_d   = 4'd0;
          nb_d    = 3'd0;
          state_d = StNeigh;
        end
      end
      StNeigh: begin
        if (on_board && is_mine) begin
          acc_d = acc_q + 4'd1;
        end
        nb_d = nb_q + 3'd1;
        if (nb_q == 3'd7) begin
          state_d = StWriteCnt;
        end
      end
      StWriteCnt: begin
        if (cell_q == LastCell) begin
          state_d = StDone;
        end else begin
          cell_d  = cell_q + 5'd1;
          state_d = StCheck;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cell_q  <= 5'd0;
      nb_q    <= 3'd0;
      acc_q   <= 4'd0;
      mines_q <= 5'd0;
      lfsr_q  <= 8'h01;
      cand_q  <= 5'd0;
      safe_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      nb_q    <= nb_d;
      acc_q   <= acc_d;
      mines_q <= mines_d;
      lfsr_q  <= lfsr_d;
      cand_q  <= cand_d;
      safe_q  <= safe_d;
    end
  end

endmodule

// File: tb/tb_board_generator.sv
// Bench for board_generator: three instances (24, 5 and 1 mines) each on its
// own behavioural RAM, checked against a reference model of mine placement.
module tb_board_generator;

  logic        clk;
  logic        reset;
  logic        start [3];
  logic [7:0]  seed [3];
  logic [4:0]  safe [3];
  logic        wen [3];
  logic [11:0] addr [3];
  logic [31:0] din [3];
  logic [31:0] dout [3];
  logic        busy [3];
  logic        done [3];

  logic [31:0] ram [3][32];
  int          wr_cnt [3];
  int          done_cnt [3];

  int tests;
  int fails;

  // Reference model results
  int exp_b [25];
  int exp_probes;
  int exp_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  board_generator #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .NUM_MINES(24)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .seed(seed[0]), .safe_cell(safe[0]),
    .mem_wEn(wen[0]), .mem_addr(addr[0]), .mem_dataIn(din[0]), .mem_dataOut(dout[0]),
    .busy(busy[0]), .done(done[0])
  );
  board_generator #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .NUM_MINES(5)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .seed(seed[1]), .safe_cell(safe[1]),
    .mem_wEn(wen[1]), .mem_addr(addr[1]), .mem_dataIn(din[1]), .mem_dataOut(dout[1]),
    .busy(busy[1]), .done(done[1])
  );
  board_generator #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .NUM_MINES(1)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .seed(seed[2]), .safe_cell(safe[2]),
    .mem_wEn(wen[2]), .mem_addr(addr[2]), .mem_dataIn(din[2]), .mem_dataOut(dout[2]),
    .busy(busy[2]), .done(done[2])
  );

  // RAMs commit on the falling edge; reads are combinational.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wen[k]) begin
        if (addr[k] < 12'd32) ram[k][addr[k][4:0]] = din[k];
        wr_cnt[k] = wr_cnt[k] + 1;
      end
      if (done[k]) done_cnt[k] = done_cnt[k] + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dout[k] = (addr[k] < 12'd32) ? ram[k][addr[k][4:0]] : 32'd0;
    end
  end

  function automatic int nm_of(input int k);
    return (k == 0) ? 24 : ((k == 1) ? 5 : 1);
  endfunction

  // Walk the LFSR sequence placing mines, then count neighbours per cell.
  task automatic model_board(input logic [7:0] sd, input int sc, input int nm);
    logic [7:0] r;
    bit         mine [25];
    int         placed, cand, cnt, rr, cc;
    r = (sd == 8'h00) ? 8'h01 : sd;
    placed = 0;
    exp_probes = 0;
    for (int c = 0; c < 25; c++) mine[c] = 1'b0;
    while (placed < nm && exp_probes < 5000) begin
      cand = int'(r) % 32;
      exp_probes++;
      if (cand < 25 && cand != sc && !mine[cand]) begin
        mine[cand] = 1'b1;
        placed++;
      end
      r = {r[6:0], ^(r & 8'hB8)};
    end
    exp_q = 0;
    while (exp_q < 25 && mine[exp_q]) exp_q++;
    for (int c = 0; c < 25; c++) begin
      if (mine[c]) begin
        exp_b[c] = 10;
      end else begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = c / 5 + dr;
            cc = c % 5 + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 5 && cc >= 0 && cc < 5 &&
                mine[rr * 5 + cc]) cnt++;
          end
        end
        exp_b[c] = cnt;
      end
    end
  endtask

  function automatic int count_mines(input int k);
    int n;
    n = 0;
    for (int c = 0; c < 25; c++) if (ram[k][c] == 32'd10) n++;
    return n;
  endfunction

  // One full generation with protocol, latency and board checks.
  // With inj set, start is re-pulsed (different seed) mid-NEIGH of the first count cell.
  task automatic run_board(input int k, input logic [7:0] sd, input logic [4:0] sc,
                           input bit inj, input logic [7:0] inj_seed);
    int n, lat, d0, mism, bad_cell, inj_at, nm;
    nm = nm_of(k);
    model_board(sd, int'(sc), nm);
    n = 25 + exp_probes + nm + nm + 10 * (25 - nm);
    inj_at = inj ? 25 + exp_probes + nm + exp_q + 4 : -1;
    for (int i = 0; i < 32; i++) ram[k][i] = 32'($urandom_range(0, 12));
    @(negedge clk);
    seed[k]  = sd;
    safe[k]  = sc;
    start[k] = 1'b1;
    d0 = done_cnt[k];
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    seed[k]  = 8'($urandom);
    safe[k]  = 5'($urandom);
    tests++;
    if (busy[k] !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start dut%0d: got %b expected 1", k, busy[k]);
    end
    lat = 0;
    while (done[k] !== 1'b1 && lat < n + 100) begin
      if (lat == inj_at) begin
        start[k] = 1'b1;
        seed[k]  = inj_seed;
      end
      @(posedge clk);
      #1;
      start[k] = 1'b0;
      lat++;
    end
    tests++;
    if (lat != n || done[k] !== 1'b1) begin
      fails++;
      $display("FAIL done_latency dut%0d: got %0d cycles (done=%b) expected %0d", k, lat,
               done[k], n);
    end
    tests++;
    if (busy[k] !== 1'b0 || wen[k] !== 1'b0) begin
      fails++;
      $display("FAIL done_cycle_outputs dut%0d: got busy=%b wen=%b expected 0 0", k,
               busy[k], wen[k]);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (done_cnt[k] - d0 != 1 || busy[k] !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse dut%0d: got %0d pulses busy=%b expected 1 pulse busy=0", k,
               done_cnt[k] - d0, busy[k]);
    end
    mism = 0;
    bad_cell = -1;
    for (int c = 0; c < 25; c++) begin
      if (ram[k][c] !== 32'(exp_b[c])) begin
        mism++;
        if (bad_cell < 0) bad_cell = c;
      end
    end
    tests++;
    if (mism != 0) begin
      fails++;
      $display("FAIL board dut%0d seed=%h: %0d cells wrong, cell %0d got %0d expected %0d",
               k, sd, mism, bad_cell, ram[k][bad_cell], exp_b[bad_cell]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      seed[k]  = 8'h00;
      safe[k]  = 5'd0;
      wr_cnt[k] = 0;
      done_cnt[k] = 0;
      for (int i = 0; i < 32; i++) ram[k][i] = 32'd0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (busy[k] !== 1'b0 || done[k] !== 1'b0 || wen[k] !== 1'b0 || addr[k] !== 12'd0 ||
          din[k] !== 32'd0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: got busy=%b done=%b wen=%b addr=%0d din=%0d expected all 0",
                 k, busy[k], done[k], wen[k], addr[k], din[k]);
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (wr_cnt[0] + wr_cnt[1] + wr_cnt[2] != 0 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL idle_quiet: got %0d writes busy=%b expected 0 writes busy=0",
               wr_cnt[0] + wr_cnt[1] + wr_cnt[2], busy[0]);
    end
  endtask

  task automatic test_full_board();
    run_board(0, 8'hA5, 5'd12, 1'b0, 8'h00);
    tests++;
    if (ram[0][12] !== 32'd8 || count_mines(0) != 24) begin
      fails++;
      $display("FAIL full_board_safe_centre: got cell12=%0d mines=%0d expected 8 24",
               ram[0][12], count_mines(0));
    end
  endtask

  task automatic test_safe_corner();
    run_board(0, 8'($urandom_range(1, 255)), 5'd0, 1'b0, 8'h00);
    tests++;
    if (ram[0][0] !== 32'd3 || count_mines(0) != 24) begin
      fails++;
      $display("FAIL full_board_safe_corner: got cell0=%0d mines=%0d expected 3 24",
               ram[0][0], count_mines(0));
    end
  endtask

  task automatic test_sparse();
    logic [7:0] seeds [2];
    seeds[0] = 8'h00;
    seeds[1] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      run_board(1, seeds[i], 5'd7, 1'b0, 8'h00);
      tests++;
      if (count_mines(1) != 5 || ram[1][7] === 32'd10) begin
        fails++;
        $display("FAIL sparse seed=%h: got mines=%0d cell7=%0d expected 5 and not 10",
                 seeds[i], count_mines(1), ram[1][7]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int w;
    @(negedge clk);
    seed[0]  = 8'h11;
    safe[0]  = 5'd3;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (wen[0] !== 1'b1 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL in_clear: got wen=%b busy=%b expected 1 1", wen[0], busy[0]);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (wen[0] !== 1'b0 || busy[0] !== 1'b0 || addr[0] !== 12'd0) begin
      fails++;
      $display("FAIL reset_async: got wen=%b busy=%b addr=%0d expected 0 0 0", wen[0],
               busy[0], addr[0]);
    end
    w = wr_cnt[0];
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (wr_cnt[0] != w || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL writes_after_reset: got %0d extra writes busy=%b expected 0 0",
               wr_cnt[0] - w, busy[0]);
    end
    run_board(0, 8'h77, 5'd20, 1'b0, 8'h00);
  endtask

  task automatic test_start_in_neigh();
    run_board(1, 8'h5B, 5'd18, 1'b1, 8'hC3);
  endtask

  task automatic test_single_mine();
    int m, bad, rr, cc;
    run_board(2, 8'($urandom), 5'd31, 1'b0, 8'h00);
    m = -1;
    for (int c = 0; c < 25; c++) if (ram[2][c] == 32'd10) m = c;
    bad = 0;
    if (m >= 0) begin
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          rr = m / 5 + dr;
          cc = m % 5 + dc;
          if ((dr != 0 || dc != 0) && rr >= 0 && rr < 5 && cc >= 0 && cc < 5 &&
              ram[2][rr * 5 + cc] < 32'd1) bad++;
        end
      end
    end
    tests++;
    if (count_mines(2) != 1 || m < 0 || bad != 0) begin
      fails++;
      $display("FAIL single_mine: got mines=%0d zero_neighbours=%0d expected 1 0",
               count_mines(2), bad);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_board(1 + (i % 2), 8'($urandom), 5'($urandom_range(0, 31)), 1'b0, 8'h00);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_full_board();
    test_safe_corner();
    test_sparse();
    test_reset_mid_clear();
    test_start_in_neigh();
    test_single_mine();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_generator.md
BOARD_GENERATOR -- requirements
Module: board_generator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the board RAM word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 12, the board RAM address width.
REQ-003 SHALL have parameter NUM_MINES, default 5, the number of mines placed; legal range 1..24.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit, one-cycle request to generate a new board.
REQ-007 SHALL have port seed, input, 8 bits, LFSR seed, sampled when start is accepted.
REQ-008 SHALL have port safe_cell, input, 5 bits, cell index (row*5+col) that must not hold a mine; values >=25 mean no exclusion.
REQ-009 SHALL have port mem_wEn, output, 1 bit, board RAM write enable.
REQ-010 SHALL have port mem_addr, output, ADDRESS_WIDTH bits, board RAM shared read/write address.
REQ-011 SHALL have port mem_dataIn, output, DATA_WIDTH bits, board RAM write data.
REQ-012 SHALL have port mem_dataOut, input, DATA_WIDTH bits, combinational RAM read data at mem_addr.
REQ-013 SHALL have port busy, output, 1 bit, high from start acceptance until done.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse when the board is complete.

Function
REQ-015 SHALL treat the board as 5x5 cells at addresses 0..24; mine = 10; non-mine = neighbour mine count 0..8, zero-extended to DATA_WIDTH.
REQ-016 SHALL make mem_wEn, mem_addr and mem_dataIn Moore outputs (decoded from registered state only); RAM commits writes on the falling clock edge.
REQ-017 SHALL implement states IDLE, CLEAR, PROBE, WRITE_MINE, CHECK, NEIGH, WRITE_CNT and DONE.
REQ-018 SHALL in IDLE, on start=1, latch safe_cell, load the LFSR with seed (8'h01 if seed==0), set busy=1 and enter CLEAR.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL in CLEAR write 0 to addresses 0..24 (one per cycle, 25 cycles), then enter PROBE.
REQ-021 SHALL use an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing once per PROBE cycle; candidate = lfsr[4:0].
REQ-022 SHALL in PROBE drive mem_addr=candidate with mem_wEn=0; accept the candidate if it is <25, not equal to safe_cell, and mem_dataOut!=10; otherwise stay in PROBE with the next candidate.
REQ-023 SHALL on accept enter WRITE_MINE, writing 10 to the candidate (1 cycle) and incrementing the mine counter; when the counter reaches NUM_MINES, enter CHECK at cell 0, else return to PROBE.
REQ-024 SHALL in CHECK read cell c (1 cycle): if it is 10, advance to c+1; otherwise clear the accumulator and enter NEIGH.
REQ-025 SHALL in NEIGH spend exactly 8 cycles on offsets (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1), adding 1 when the neighbour is on-board and reads 10; for off-board neighbours drive mem_addr=c and add nothing.
REQ-026 SHALL in WRITE_CNT write the accumulator to cell c (1 cycle), then advance to c+1.
REQ-027 SHALL after cell 24 enter DONE: done=1 for exactly 1 cycle, busy=0 from that cycle onward, mem_wEn=0; then return to IDLE.
REQ-028 SHALL drive mem_wEn=1 only in CLEAR, WRITE_MINE and WRITE_CNT.

Reset
REQ-029 SHALL on reset=1, immediately and regardless of clk, force state IDLE, busy=0, done=0, mem_wEn=0, mem_addr=0, mem_dataIn=0, mine counter=0 and LFSR=8'h01.
REQ-030 SHALL, when reset is asserted mid-generation, abandon the board with no further writes; RAM contents are then unspecified until the next start.

Verification
REQ-031 SHALL cover: NUM_MINES=24, safe_cell=12, seed=8'hA5 -> 24 cells read 10, cell 12 reads 8, one done pulse, busy low afterwards.
REQ-032 SHALL cover: NUM_MINES=24, safe_cell=0 -> cell 0 reads 3, every other cell reads 10.
REQ-033 SHALL cover: NUM_MINES=5, seeds 8'h00 and 8'h3C, safe_cell=7 -> exactly 5 cells read 10, cell 7 is not 10, every non-mine cell equals its true neighbour mine count.
REQ-034 SHALL cover: reset pulsed 10 cycles into CLEAR -> mem_wEn=0 and busy=0 in the same cycle, no writes afterwards; a following start completes a valid board.
REQ-035 SHALL cover: start re-asserted during NEIGH -> no restart, a single done pulse, board valid.
REQ-036 SHALL cover: safe_cell=31, NUM_MINES=1 -> exactly one cell reads 10 (any index permitted); its in-board neighbours read >=1.
